// File: rtl/disp_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display.
// Host writes land in a shadow bank, and the shadow bank is copied to the active bank
// once per frame, so a displayed frame never mixes old and new digits.
// Each digit gets a dead-time slot and then an ON slot. During the ON slot the digit is
// PWM-dimmed, and it can also be blanked or blinked.
// Optional feature: define BLINK_EN to build the blink-phase frame counter.
module disp_scan_ctrl #(
  parameter int unsigned Prescale    = 50000,  // ON cycles per digit, multiple of 16
  parameter int unsigned Dead        = 4,      // all-off cycles between digits, >= 1
  parameter int unsigned BlinkFrames = 64      // frames per blink half-period
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  input  logic [1:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic [3:0] brightness_i,
  input  logic [3:0] blank_mask_i,
  input  logic [3:0] blink_mask_i,
  output logic [3:0] an_o,
  output logic [7:0] sseg_o,
  output logic       frame_tick_o
);

  localparam int unsigned MaxCnt = (Prescale > Dead) ? Prescale : Dead;
  localparam int unsigned CntW   = $clog2(MaxCnt);

  typedef enum logic [1:0] {StDead, StOn, StCommit} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        digit_q, digit_d;
  logic [3:0][7:0]   shadow_q, active_q;
  logic              dirty_q;
  logic [3:0]        an_d;
  logic [7:0]        sseg_d;
  logic              tick_d;
  logic              lit;
  logic              blink_phase;
  logic              commit;
  logic              wr_fire;

  assign commit  = (state_q == StCommit);
  assign wr_fire = wr_valid_i && wr_ready_o;

  // State, slot counter and digit index register
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= StDead;
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  // Next-state: DEAD -> ON per digit, then one COMMIT cycle after digit 3
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    unique case (state_q)
      StDead: begin
        if (cnt_q == CntW'(Dead - 1)) begin
          state_d = StOn;
          cnt_d   = '0;
        end
      end
      StOn: begin
        if (cnt_q == CntW'(Prescale - 1)) begin
          cnt_d = '0;
          if (digit_q == 2'd3) begin
            state_d = StCommit;
          end else begin
            digit_d = digit_q + 2'd1;
            state_d = StDead;
          end
        end
      end
      StCommit: begin
        state_d = StDead;
        cnt_d   = '0;
        digit_d = '0;
      end
      default: begin
        state_d = StDead;
        cnt_d   = '0;
        digit_d = '0;
      end
    endcase
  end

  // Output decode: lit digit drives its anode and pattern, else everything dark
  always_comb begin
    wr_ready_o = !commit;
    tick_d     = commit;
    lit        = (state_q == StOn) && (cnt_q[3:0] < brightness_i) &&
                 !blank_mask_i[digit_q] && !(blink_phase && blink_mask_i[digit_q]);
    an_d       = 4'hF;
    sseg_d     = 8'hFF;
    if (lit) begin
      an_d   = ~(4'b0001 << digit_q);
      sseg_d = active_q[digit_q];
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      an_o         <= 4'hF;
      sseg_o       <= 8'hFF;
      frame_tick_o <= 1'b0;
    end else begin
      an_o         <= an_d;
      sseg_o       <= sseg_d;
      frame_tick_o <= tick_d;
    end
  end

  // Shadow/active banks; writes are held off during COMMIT so they never collide
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      shadow_q <= '1;
      active_q <= '1;
      dirty_q  <= 1'b0;
    end else begin
      if (wr_fire) begin
        shadow_q[wr_addr_i] <= wr_data_i;
        dirty_q             <= 1'b1;
      end
      if (commit) begin
        dirty_q <= 1'b0;
        if (dirty_q) begin
          active_q <= shadow_q;
        end
      end
    end
  end

`ifdef BLINK_EN
  localparam int unsigned BlkW = (BlinkFrames > 1) ? $clog2(BlinkFrames) : 1;

  logic [BlkW-1:0] blink_cnt_q;
  logic            blink_phase_q;

  // Count commits; flip the blink phase every BlinkFrames frames
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (commit) begin
      if (blink_cnt_q == BlkW'(BlinkFrames - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blink_phase = blink_phase_q;
`else
  logic unused_blink;

  assign blink_phase  = 1'b0;
  assign unused_blink = ^{blink_mask_i, BlinkFrames[0]};
`endif

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with Prescale=16, Dead=2, BlinkFrames=2.
// A frame is 73 cycles. State index s counts clock edges since reset release.
// Within a frame (base B): d0 ON at B+2..17, d1 at B+20..35, d2 at B+38..53,
// d3 at B+56..71, commit at B+72.
// Registered outputs for state s are visible at the negedge once tcyc == s+1.
module tb_disp_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] brightness;
  logic [3:0] blank_mask;
  logic [3:0] blink_mask;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;
  int tcyc  = 0;

  typedef struct {
    int         s;
    logic [3:0] br;
    logic [3:0] blank;
    logic [3:0] blink;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       ft;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];

  disp_scan_ctrl #(
    .Prescale   (16),
    .Dead       (2),
    .BlinkFrames(2)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (rst_n),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .brightness_i(brightness),
    .blank_mask_i(blank_mask),
    .blink_mask_i(blink_mask),
    .an_o        (an),
    .sseg_o      (sseg),
    .frame_tick_o(frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) tcyc <= 0;
    else        tcyc <= tcyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Advance to the negedge where state s is current, so inputs set here affect state s
  task automatic wait_tc(input int s);
    int guard = 0;
    if (tcyc > s) begin
      total++;
      bad++;
      $display("FAIL sched: tcyc %0d past target %0d", tcyc, s);
    end
    while (tcyc < s) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        bad++;
        $display("FAIL timeout: tcyc %0d target %0d", tcyc, s);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic add(inout vec_t q[$], input int s, input logic [3:0] br, input logic [3:0] bl,
                     input logic [3:0] bk, input logic [3:0] a, input logic [7:0] sg,
                     input logic ft);
    vec_t v;
    v.s = s; v.br = br; v.blank = bl; v.blink = bk; v.an = a; v.sseg = sg; v.ft = ft;
    q.push_back(v);
  endtask

  task automatic run_tab(input vec_t q[$], input string tag);
    foreach (q[i]) begin
      wait_tc(q[i].s);
      brightness = q[i].br;
      blank_mask = q[i].blank;
      blink_mask = q[i].blink;
      @(negedge clk);
      chk($sformatf("%s%0d.an", tag, i), 32'(an), 32'(q[i].an));
      chk($sformatf("%s%0d.sseg", tag, i), 32'(sseg), 32'(q[i].sseg));
      chk($sformatf("%s%0d.tick", tag, i), 32'(frame_tick), 32'(q[i].ft));
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  logic [3:0] bk_an;
  logic [7:0] bk_sg;
  int lit_cnt;
  int d2_cnt;

  initial begin
`ifdef BLINK_EN
    bk_an = 4'hF;  bk_sg = 8'hFF;
`else
    bk_an = 4'hE;  bk_sg = 8'h99;
`endif
    // Frame 1 shows the reset bank; frames 2-3 check data, PWM and blanking
    add(tab_a,  20, 15, 4'h0, 4'h0, 4'hD, 8'hFF, 1'b0);
    add(tab_a,  38, 15, 4'h0, 4'h0, 4'hB, 8'hFF, 1'b0);
    add(tab_a,  72, 15, 4'h0, 4'h0, 4'hF, 8'hFF, 1'b1);
    add(tab_a,  75, 15, 4'h0, 4'h0, 4'hE, 8'hC0, 1'b0);
    add(tab_a,  89, 15, 4'h0, 4'h0, 4'hE, 8'hC0, 1'b0);
    add(tab_a,  90, 15, 4'h0, 4'h0, 4'hF, 8'hFF, 1'b0);
    add(tab_a,  91, 15, 4'h0, 4'h0, 4'hF, 8'hFF, 1'b0);
    add(tab_a,  93, 15, 4'h0, 4'h0, 4'hD, 8'hF9, 1'b0);
    add(tab_a, 111, 15, 4'h0, 4'h0, 4'hB, 8'hA4, 1'b0);
    add(tab_a, 129, 15, 4'h0, 4'h0, 4'h7, 8'hB0, 1'b0);
    add(tab_a, 148,  0, 4'h0, 4'h0, 4'hF, 8'hFF, 1'b0);
    add(tab_a, 163,  0, 4'h0, 4'h0, 4'hF, 8'hFF, 1'b0);
    add(tab_a, 166,  4, 4'h0, 4'h0, 4'hD, 8'hF9, 1'b0);
    add(tab_a, 169,  4, 4'h0, 4'h0, 4'hD, 8'hF9, 1'b0);
    add(tab_a, 170,  4, 4'h0, 4'h0, 4'hF, 8'hFF, 1'b0);
    add(tab_a, 184, 15, 4'h4, 4'h0, 4'hF, 8'hFF, 1'b0);
    add(tab_a, 189, 15, 4'h4, 4'h0, 4'hF, 8'hFF, 1'b0);
    add(tab_a, 202, 15, 4'h4, 4'h0, 4'h7, 8'hB0, 1'b0);
    // Frames 6-11: held-off write, last-write-wins, blink phases
    add(tab_b, 380, 15, 4'h0, 4'h0, 4'hE, 8'hC0, 1'b0);
    add(tab_b, 437, 15, 4'h0, 4'h0, 4'hF, 8'hFF, 1'b1);
    add(tab_b, 440, 15, 4'h0, 4'h0, 4'hE, 8'h99, 1'b0);
    add(tab_b, 458, 15, 4'h0, 4'h0, 4'hD, 8'h22, 1'b0);
    add(tab_b, 513, 15, 4'h0, 4'h1, bk_an, bk_sg, 1'b0);
    add(tab_b, 531, 15, 4'h0, 4'h1, 4'hD, 8'h22, 1'b0);
    add(tab_b, 586, 15, 4'h0, 4'h1, 4'hE, 8'h99, 1'b0);
    add(tab_b, 732, 15, 4'h0, 4'h1, bk_an, bk_sg, 1'b0);

    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    brightness = 4'd15; blank_mask = '0; blink_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst.an", 32'(an), 32'hF);
    chk("rst.sseg", 32'(sseg), 32'hFF);
    chk("rst.tick", 32'(frame_tick), 32'h0);
    chk("rst.ready", 32'(wr_ready), 32'h1);
    rst_n = 1'b1;

    wr(2'd0, 8'hC0);
    wr(2'd1, 8'hF9);
    wr(2'd2, 8'hA4);
    wr(2'd3, 8'hB0);
    run_tab(tab_a, "a");

    // Frame 4: brightness 4 with d2 blanked -> 3 digits x 4 lit cycles
    wait_tc(219);
    brightness = 4'd4;
    blank_mask = 4'h4;
    lit_cnt = 0;
    d2_cnt  = 0;
    for (int i = 0; i < 73; i++) begin
      @(negedge clk);
      if (an != 4'hF) lit_cnt++;
      if (an == 4'hB) d2_cnt++;
    end
    chk("pwm.lit", 32'(lit_cnt), 32'd12);
    chk("blank.d2", 32'(d2_cnt), 32'd0);
    brightness = 4'd15;
    blank_mask = '0;

    // Write offered in the COMMIT cycle of frame 5 is held off for one cycle
    wait_tc(364);
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 8'h99;
    chk("hs.ready_commit", 32'(wr_ready), 32'h0);
    @(negedge clk);
    chk("hs.ready_after", 32'(wr_ready), 32'h1);
    chk("hs.tick", 32'(frame_tick), 32'h1);
    @(posedge clk);
    #1 wr_valid = 1'b0;

    wait_tc(370);
    wr(2'd1, 8'h11);
    wr(2'd1, 8'h22);
    run_tab(tab_b, "b");
    blink_mask = '0;

    // Reset during digit 2 ON in frame 12
    wait_tc(843);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid.an", 32'(an), 32'hF);
    chk("mid.sseg", 32'(sseg), 32'hFF);
    chk("mid.ready", 32'(wr_ready), 32'h1);
    chk("mid.tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    wait_tc(20);
    @(negedge clk);
    chk("post.f1.an", 32'(an), 32'hD);
    chk("post.f1.sseg", 32'(sseg), 32'hFF);
    wait_tc(93);
    @(negedge clk);
    chk("post.f2.an", 32'(an), 32'hD);
    chk("post.f2.sseg", 32'(sseg), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
